i2c_xact_ctrl: RTL
==================

# i2c_xact_ctrl

Transaction sequencer placed between the APB register block and the bit-level I2C engine. It accepts one register-style I2C transaction at a time: device address, register address, and a write or read of one data byte. It expands the transaction into a stream of bit commands (START, WRITE bit, READ bit, STOP) with a valid/ready/done handshake. It returns the read byte and the ACK/NACK status to the register block.

## Interface
- `NACK_ABORT`, default 1. Meaning: 1 = on a NACK, abort to STOP. 0 = log the NACK and continue the sequence.
- `PCLK`  in  1. System clock. All logic samples on its rising edge.
- `PRESETn`  in  1. Reset: one clock; synchronous; active-low.
- `start`  in  1. One-cycle request pulse. Ignored while `busy`=1.
- `rw`  in  1. 0 = write, 1 = read. Sampled with `start`.
- `dev_addr`  in  7. 7-bit slave address. Sampled with `start`.
- `reg_addr`  in  8. Slave register index. Sampled with `start`.
- `wdata`  in  8. Write data byte. Sampled with `start`.
- `busy`  out  1. High from the cycle after `start` is accepted until the cycle `done` pulses (inclusive).
- `done`  out  1. One-cycle completion pulse.
- `rdata`  out  8. Read byte. Valid from `done` until the next accepted `start`.
- `nack_err`  out  1. Set if any slave ACK slot returned 1. Updated at `done`, cleared on accept.
- `bit_cmd`  out  2. Bit command: 00 START, 01 STOP, 10 WRITE, 11 READ.
- `bit_wdata`  out  1. Bit value for a WRITE command.
- `bit_valid`  out  1. Command request. Held until accepted.
- `bit_ready`  in  1. Engine accepts the command when `bit_valid`&`bit_ready`.
- `bit_done`  in  1. One-cycle pulse when the accepted command has completed on the bus.
- `bit_rdata`  in  1. Sampled SDA value for a READ command. Valid with `bit_done`.

## Operation
- Sampling: on an accepted `start`, latch `rw`, `dev_addr`, `reg_addr` and `wdata`.
- Write sequence: START, {dev_addr,0} (8 bits), ACK slot, reg_addr (8), ACK slot, wdata (8), ACK slot, STOP. Total 29 commands.
- Read sequence: START, {dev_addr,0}, ACK, reg_addr, ACK, START (repeated), {dev_addr,1}, ACK, 8 × READ, master NACK (WRITE with `bit_wdata`=1), STOP. Total 39 commands.
- Byte transmit:
  - Bytes are sent MSB first from an 8-bit shift register.
  - `bit_wdata` = shift[7]; shift left after each `bit_done`.
- ACK slot:
  - Issue a READ command.
  - `bit_rdata`=0 is an ACK; `bit_rdata`=1 is a NACK and sets the sticky `nack_err`.
- NACK handling:
  - If `NACK_ABORT`=1, the next command after the NACK slot is STOP, then DONE.
  - If `NACK_ABORT`=0, the sequence continues unchanged.
- Read byte: shift `bit_rdata` in from the LSB side on each `bit_done`. After 8 bits the byte is MSB-correct and is copied to `rdata` at `done`.
- State machine (states): IDLE, START, TX_BYTE, TX_ACK, RSTART, RX_BYTE, RX_NACK, STOP, DONE.
  - IDLE→START on accepted `start`.
  - START→TX_BYTE.
  - TX_BYTE→TX_ACK after bit 8.
  - TX_ACK→TX_BYTE (next byte) / RSTART (read, after reg_addr) / RX_BYTE (read, after second address) / STOP (write, after data byte, or abort).
  - RSTART→TX_BYTE.
  - RX_BYTE→RX_NACK after bit 8.
  - RX_NACK→STOP.
  - STOP→DONE.
  - DONE→IDLE.
- Bookkeeping: a 3-bit bit counter and a 2-bit byte index select the next byte and the next state.
- Reset values: `busy`=0, `done`=0, `rdata`=0, `nack_err`=0, `bit_valid`=0, `bit_cmd`=00, `bit_wdata`=1, state IDLE.
- Reset mid-transaction: all outputs go to their reset values at the first clock edge with `PRESETn`=0. No STOP is issued; the engine is reset by the same `PRESETn`.
- `start` while busy: dropped. It is not queued.

## Timing
- Issue timing: every command in a transaction is presented with `bit_valid`=1 in the cycle after the previous `bit_done`.
- Handshake:
  - At most one command is outstanding.
  - `bit_cmd` and `bit_wdata` stay stable while `bit_valid`=1 and `bit_ready`=0.
  - `bit_valid` drops in the cycle after acceptance.
- `bit_done` arriving in the acceptance cycle is ignored. The earliest legal `bit_done` is the cycle after acceptance.
- Start of transaction: `start` at cycle N gives `busy`=1 at N+1, and the first `bit_valid` (START) at N+1.
- End of transaction: `done` pulses 1 cycle after the `bit_done` of STOP, while `busy`=1. `busy` falls the cycle after `done`.
- Back-to-back: a `start` in the cycle after `busy` falls is accepted.
- Minimum transaction length, with an engine that is always ready and a 1-cycle `bit_done`:
  - write: 29×2 + 2 cycles;
  - read: 39×2 + 2 cycles.

## Test plan
- Write with ACKs: dev 0x50, reg 0x12, wdata 0xA5 → 29 commands. Bit stream: START, 1010000 0, A, 00010010, A, 10100101, A, STOP. `done` pulses once; `nack_err`=0.
- Read with ACKs: dev 0x50, reg 0x03, slave returns 0x3C → 39 commands, with a repeated START before address byte 0xA1. Master NACK has `bit_wdata`=1. `rdata`=0x3C; `nack_err`=0.
- Address NACK with `NACK_ABORT`=1: `bit_rdata`=1 in the first ACK slot → next command is STOP, then `done`; `nack_err`=1. Total 11 commands.
- Backpressure: hold `bit_ready`=0 for 5 cycles on each command → `bit_cmd` and `bit_wdata` stay stable. `start` pulses while busy are ignored, and the command sequence is identical to the write case.
- Reset mid-transaction: assert `PRESETn`=0 during the reg_addr byte → the next edge gives `busy`=0, `bit_valid`=0, state IDLE. A new write after release completes normally.
- `NACK_ABORT`=0: data-byte NACK on a write → STOP is issued in the normal position; `done` pulses; `nack_err`=1.

Source files
------------

// File: rtl/i2c_xact_ctrl.sv
// Transaction sequencer: turns one register-style I2C write or read into a
// stream of START/WRITE/READ/STOP bit commands for the bit-level engine.
module i2c_xact_ctrl #(
  parameter int NACK_ABORT = 1
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nack_err,
  output logic [1:0] bit_cmd,
  output logic       bit_wdata,
  output logic       bit_valid,
  input  logic       bit_ready,
  input  logic       bit_done,
  input  logic       bit_rdata
);
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TX_BYTE, S_TX_ACK, S_RSTART,
    S_RX_BYTE, S_RX_NACK, S_STOP, S_DONE
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  state_t     state, state_nx;
  logic       accept, step, abort_now;
  logic       outstanding, nack_seen;
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic       rw_lat;
  logic [6:0] dev_lat;
  logic [7:0] reg_lat, wdata_lat, tx_shift, rx_shift;

  function automatic logic issues_cmd(input state_t s);
    return !(s == S_IDLE || s == S_DONE);
  endfunction

  assign accept    = start && (state == S_IDLE);
  // bit_done only counts once the command was accepted in an earlier cycle
  assign step      = outstanding && bit_done;
  assign abort_now = (NACK_ABORT != 0) && bit_rdata;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    bit_cmd   = CMD_START;
    bit_wdata = 1'b1;
    case (state)
      S_IDLE:    if (accept) state_nx = S_START;
      S_START: begin
        bit_cmd = CMD_START;
        if (step) state_nx = S_TX_BYTE;
      end
      S_TX_BYTE: begin
        bit_cmd   = CMD_WRITE;
        bit_wdata = tx_shift[7];
        if (step && bit_cnt == 3'd7) state_nx = S_TX_ACK;
      end
      S_TX_ACK: begin
        bit_cmd = CMD_READ;
        if (step) begin
          if (abort_now) state_nx = S_STOP;
          else begin
            case (byte_idx)
              2'd0:    state_nx = S_TX_BYTE;
              2'd1:    state_nx = rw_lat ? S_RSTART : S_TX_BYTE;
              default: state_nx = rw_lat ? S_RX_BYTE : S_STOP;
            endcase
          end
        end
      end
      S_RSTART: begin
        bit_cmd = CMD_START;
        if (step) state_nx = S_TX_BYTE;
      end
      S_RX_BYTE: begin
        bit_cmd = CMD_READ;
        if (step && bit_cnt == 3'd7) state_nx = S_RX_NACK;
      end
      S_RX_NACK: begin
        bit_cmd   = CMD_WRITE;
        bit_wdata = 1'b1;
        if (step) state_nx = S_STOP;
      end
      S_STOP: begin
        bit_cmd = CMD_STOP;
        if (step) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      bit_valid   <= 1'b0;
      outstanding <= 1'b0;
      rdata       <= 8'h00;
      nack_err    <= 1'b0;
      nack_seen   <= 1'b0;
      bit_cnt     <= 3'd0;
      byte_idx    <= 2'd0;
    end else begin
      bit_valid   <= accept || (step && issues_cmd(state_nx)) || (bit_valid && !bit_ready);
      outstanding <= (bit_valid && bit_ready) || (outstanding && !bit_done);
      if (accept) begin
        nack_seen <= 1'b0;
        nack_err  <= 1'b0;
        bit_cnt   <= 3'd0;
        byte_idx  <= 2'd0;
      end
      if (step) begin
        case (state)
          S_TX_BYTE, S_RX_BYTE: bit_cnt <= bit_cnt + 3'd1;
          S_TX_ACK: begin
            byte_idx <= byte_idx + 2'd1;
            if (bit_rdata) nack_seen <= 1'b1;
          end
          S_STOP: begin
            rdata    <= rx_shift;
            nack_err <= nack_seen;
          end
          default: ;
        endcase
      end
    end
  end

  // Transaction fields and shift registers carry no reset; they are loaded before use
  always_ff @(posedge PCLK) begin
    if (accept) begin
      rw_lat    <= rw;
      dev_lat   <= dev_addr;
      reg_lat   <= reg_addr;
      wdata_lat <= wdata;
      rx_shift  <= 8'h00;
    end
    if (step) begin
      case (state)
        S_START:   tx_shift <= {dev_lat, 1'b0};
        S_RSTART:  tx_shift <= {dev_lat, 1'b1};
        S_TX_BYTE: tx_shift <= {tx_shift[6:0], 1'b0};
        S_TX_ACK:  tx_shift <= (byte_idx == 2'd0) ? reg_lat : wdata_lat;
        S_RX_BYTE: rx_shift <= {rx_shift[6:0], bit_rdata};
        default: ;
      endcase
    end
  end
endmodule
